// File: rtl/dac_init_seq_spi.sv
// dac_init_seq_spi: power-on sequencer and channel rewriter for AD56x8 octal DACs over SPI
module dac_init_seq_spi #(
  parameter int N_CH    = 8,
  parameter int DATA_W  = 12,
  parameter int CLK_DIV = 5,
  parameter int CS_GAP  = 8,
  parameter int INT_REF = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [N_CH*DATA_W-1:0]   ch_code,
  input  logic [N_CH-1:0]          upd_req,
  output logic [N_CH-1:0]          upd_ack,
  output logic                     busy,
  output logic                     init_done,
  output logic                     sclk,
  output logic                     mosi,
  output logic                     cs_n
);
  localparam int CW = $clog2(CLK_DIV + CS_GAP + 1);
  localparam logic [7:0] MASK = 8'((1 << N_CH) - 1);
  typedef enum logic [2:0] {IDLE, LOAD, CSLOW, SHIFT, CSHIGH, GAP, RUN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0] bit_q, bit_d;
  logic [31:0] frame_q, frame_d;
  logic [3:0] step_q, step_d;
  logic [2:0] ch_q, ch_d, req_ch, tgt;
  logic init_q, init_d;
  logic [N_CH-1:0] upd_ack_q, upd_ack_d;
  logic busy_q, busy_d, init_done_q, init_done_d;
  logic sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d;
  logic [DATA_W-1:0] code;
  logic half_end, gap_end;
  always_comb begin
    req_ch = '0;
    for (int i = N_CH - 1; i >= 0; i--) if (upd_req[i]) req_ch = 3'(i);
    tgt = init_q ? 3'(step_q - 4'd2) : ch_q;
    code = ch_code[int'(tgt)*DATA_W +: DATA_W];
    half_end = cnt_q == CW'(CLK_DIV - 1);
    gap_end = cnt_q == CW'(CS_GAP - 1);
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    bit_d = bit_q;
    frame_d = frame_q;
    step_d = step_q;
    ch_d = ch_q;
    init_d = init_q;
    upd_ack_d = '0;
    busy_d = busy_q;
    init_done_d = init_done_q;
    sclk_d = sclk_q;
    mosi_d = mosi_q;
    cs_n_d = cs_n_q;
    case (state_q)
      IDLE, RUN: begin
        if (start) begin
          state_d = LOAD;
          init_d = 1'b1;
          step_d = '0;
          busy_d = 1'b1;
          init_done_d = 1'b0;
        end else if (state_q == RUN && |upd_req) begin
          state_d = LOAD;
          init_d = 1'b0;
          ch_d = req_ch;
          busy_d = 1'b1;
        end
      end
      LOAD: begin
        // the channel code is captured here so later ch_code changes cannot corrupt the frame
        frame_d = (init_q && step_q == 4'd0) ? {8'hF8, 4'h0, 20'(INT_REF != 0)} :
                  (init_q && step_q == 4'd1) ? {8'hF4, 4'h0, 12'h0, MASK} :
                  {8'hF3, 1'b0, tgt, code, {(20 - DATA_W){1'b0}}};
        ch_d = tgt;
        state_d = CSLOW;
        cs_n_d = 1'b0;
        mosi_d = frame_d[31];
        cnt_d = '0;
      end
      CSLOW: begin
        if (half_end) begin
          state_d = SHIFT;
          sclk_d = 1'b1;
          cnt_d = '0;
          bit_d = '0;
        end
      end
      SHIFT: begin
        if (half_end) begin
          cnt_d = '0;
          if (sclk_q) sclk_d = 1'b0;
          else if (bit_q == 5'd31) state_d = CSHIGH;
          else begin
            sclk_d = 1'b1;
            bit_d = bit_q + 1'b1;
            mosi_d = frame_q[5'd30 - bit_q];
          end
        end
      end
      CSHIGH: begin
        if (half_end) begin
          state_d = GAP;
          cs_n_d = 1'b1;
          mosi_d = 1'b0;
          cnt_d = '0;
          if (!init_q || step_q >= 4'd2) upd_ack_d[ch_q] = 1'b1;
        end
      end
      GAP: begin
        if (gap_end) begin
          if (init_q && step_q != 4'(N_CH + 1)) begin
            step_d = step_q + 1'b1;
            state_d = LOAD;
          end else begin
            state_d = RUN;
            busy_d = 1'b0;
            init_done_d = init_done_q | init_q;
            init_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      frame_q <= '0;
      step_q <= '0;
      ch_q <= '0;
      init_q <= 1'b0;
      upd_ack_q <= '0;
      busy_q <= 1'b0;
      init_done_q <= 1'b0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      cs_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      frame_q <= frame_d;
      step_q <= step_d;
      ch_q <= ch_d;
      init_q <= init_d;
      upd_ack_q <= upd_ack_d;
      busy_q <= busy_d;
      init_done_q <= init_done_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      cs_n_q <= cs_n_d;
    end
  end
  assign upd_ack = upd_ack_q;
  assign busy = busy_q;
  assign init_done = init_done_q;
  assign sclk = sclk_q;
  assign mosi = mosi_q;
  assign cs_n = cs_n_q;
endmodule

// File: tb/tb_dac_init_seq_spi.sv
// tb_dac_init_seq_spi: scoreboard bench decoding SPI frames and upd_ack pulses against a reference model
module tb_dac_init_seq_spi;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [95:0] code12;
  logic [127:0] code16;
  logic [7:0] upd_req = '0, upd_ack, upd_req16 = '0, upd_ack16;
  logic busy, init_done, sclk, mosi, cs_n;
  logic busy16, done16, sclk16, mosi16, cs16;
  always #5 clk = ~clk;
  dac_init_seq_spi #(.N_CH(8), .DATA_W(12), .CLK_DIV(2), .CS_GAP(8), .INT_REF(1)) dut (
    .clk(clk), .rst(rst), .start(start), .ch_code(code12), .upd_req(upd_req), .upd_ack(upd_ack),
    .busy(busy), .init_done(init_done), .sclk(sclk), .mosi(mosi), .cs_n(cs_n));
  dac_init_seq_spi #(.N_CH(8), .DATA_W(16), .CLK_DIV(2), .CS_GAP(8), .INT_REF(1)) dut16 (
    .clk(clk), .rst(rst), .start(start), .ch_code(code16), .upd_req(upd_req16), .upd_ack(upd_ack16),
    .busy(busy16), .init_done(done16), .sclk(sclk16), .mosi(mosi16), .cs_n(cs16));
  logic [31:0] exp_q[$], cap16[$];
  logic [7:0] ack_q[$];
  int checks = 0, failures = 0;
  int nframes = 0, nb = 0, low = 0;
  logic [31:0] sh = '0, sh16 = '0;
  logic p_sclk = 1'b0, p_cs = 1'b1, p16s = 1'b0, p16c = 1'b1, in_frame = 1'b0;
  typedef struct {
    logic [7:0] req;
    logic [11:0] code;
    logic [31:0] first;
    int n;
  } vec_t;
  vec_t tbl[5];
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  // frame/ack monitor: samples on the falling clk edge, DAC shifts bits on sclk falling edges
  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
      p_sclk = 1'b0;
      p_cs = 1'b1;
      p16s = 1'b0;
      p16c = 1'b1;
    end else begin
      if (p_cs && !cs_n) begin
        in_frame = 1'b1;
        sh = '0;
        nb = 0;
        low = 0;
      end
      if (!cs_n) low++;
      if (p_sclk && !sclk && !cs_n) begin
        sh = {sh[30:0], mosi};
        nb++;
      end
      if (!p_cs && cs_n && in_frame) begin
        in_frame = 1'b0;
        nframes++;
        if (exp_q.size() == 0) check("frame_unexpected", sh, 32'hxxxx_xxxx);
        else begin
          check("frame", sh, exp_q.pop_front());
          check("cs_low_cycles", low, 132);
          check("frame_bits", nb, 32);
        end
      end
      if (upd_ack != 0) begin
        if (ack_q.size() == 0) check("ack_unexpected", {24'h0, upd_ack}, 32'h0);
        else check("ack", {24'h0, upd_ack}, {24'h0, ack_q.pop_front()});
      end
      if (p16s && !sclk16 && !cs16) sh16 = {sh16[30:0], mosi16};
      if (!p16c && cs16) cap16.push_back(sh16);
      p_sclk = sclk;
      p_cs = cs_n;
      p16s = sclk16;
      p16c = cs16;
    end
  end
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask
  task automatic push_init();
    exp_q.push_back(32'hF8000001);
    exp_q.push_back(32'hF40000FF);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({8'hF3, 4'(i), code12[i*12 +: 12], 8'h00});
      ack_q.push_back(8'(1 << i));
    end
  endtask
  task automatic wait_run(input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_busy"}, {31'b0, busy}, 32'd0);
    check({name, "_pending"}, exp_q.size(), 32'd0);
  endtask
  task automatic serve(input logic [7:0] req);
    logic [7:0] r = req;
    int n = 0;
    upd_req = r;
    while (r != 0 && n < 20000) begin
      @(negedge clk);
      n++;
      r &= ~upd_ack;
      upd_req = r;
    end
    check("serve_all_acked", {24'h0, r}, 32'h0);
  endtask
  initial begin
    int f0, n;
    logic [11:0] old;
    logic found;
    tbl[0] = '{8'b0010_0100, 12'h5A5, 32'hF325A500, 2};
    tbl[1] = '{8'b0000_0001, 12'hFFF, 32'hF30FFF00, 1};
    tbl[2] = '{8'b1000_0000, 12'h000, 32'hF3700000, 1};
    tbl[3] = '{8'b1000_0001, 12'h800, 32'hF3080000, 2};
    tbl[4] = '{8'b0101_1010, 12'h3C3, 32'hF313C300, 4};
    for (int i = 0; i < 8; i++) code12[i*12 +: 12] = 12'h4CC + 12'(i * 12'h111);
    code16 = '0;
    code16[7*16 +: 16] = 16'hABCD;
    repeat (3) @(negedge clk);
    check("rst_cs_n", {31'b0, cs_n}, 32'd1);
    check("rst_sclk", {31'b0, sclk}, 32'd0);
    check("rst_mosi", {31'b0, mosi}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_init_done", {31'b0, init_done}, 32'd0);
    check("rst_upd_ack", {24'h0, upd_ack}, 32'd0);
    @(negedge clk) rst = 1'b0;
    // power-on sequence, with a second start pulse mid-frame that must be ignored
    f0 = nframes;
    push_init();
    pulse_start();
    n = 0;
    while (cs_n && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (30) @(negedge clk);
    pulse_start();
    wait_run("init");
    check("init_done", {31'b0, init_done}, 32'd1);
    check("init_frames", nframes - f0, 32'd10);
    check("w16_frames", cap16.size(), 32'd10);
    check("w16_ch7_frame", cap16[9], 32'hF37ABCD0);
    // code changed mid-shift: frame must carry the LOAD-time code
    old = code12[36 +: 12];
    exp_q.push_back({8'hF3, 4'd3, old, 8'h00});
    ack_q.push_back(8'h08);
    upd_req = 8'h08;
    n = 0;
    while (cs_n && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (40) @(negedge clk);
    code12[36 +: 12] = ~old;
    n = 0;
    while (!upd_ack[3] && n < 400) begin
      @(negedge clk);
      n++;
    end
    upd_req = '0;
    wait_run("hold_code");
    for (int k = 0; k < 5; k++) begin
      code12 = {8{tbl[k].code}};
      f0 = nframes;
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (tbl[k].req[i]) begin
          exp_q.push_back(found ? {8'hF3, 4'(i), tbl[k].code, 8'h00} : tbl[k].first);
          ack_q.push_back(8'(1 << i));
          found = 1'b1;
        end
      end
      serve(tbl[k].req);
      wait_run("run_vec");
      check("run_vec_frames", nframes - f0, tbl[k].n);
    end
    // start while in RUN restarts the whole init
    f0 = nframes;
    push_init();
    pulse_start();
    check("restart_init_done_clr", {31'b0, init_done}, 32'd0);
    check("restart_busy", {31'b0, busy}, 32'd1);
    wait_run("restart");
    check("restart_init_done", {31'b0, init_done}, 32'd1);
    check("restart_frames", nframes - f0, 32'd10);
    // async reset at bit 17 of frame 3 aborts everything
    f0 = nframes;
    push_init();
    pulse_start();
    n = 0;
    while (!(nframes == f0 + 3 && nb == 17 && !cs_n) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("rst_reached_bit17", nb, 32'd17);
    rst = 1'b1;
    #1;
    check("abort_cs_n", {31'b0, cs_n}, 32'd1);
    check("abort_sclk", {31'b0, sclk}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_init_done", {31'b0, init_done}, 32'd0);
    exp_q.delete();
    ack_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (400) begin
      @(negedge clk);
      if (!cs_n) n++;
    end
    check("no_resume_cs_low", n, 32'd0);
    check("no_resume_busy", {31'b0, busy}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
